ddr_activation_reader: RTL and testbench

Reads packed activation bytes back from DDR in 216-bit beats (27 bytes per beat), the format the backend writes out. Unpacks them into a one-byte-per-cycle stream tagged with row/col/channel addresses for the next layer's input path. Beats arrive over a valid/ready handshake; the output stream applies back-pressure through its own valid/ready handshake. One beat buffer, address counters and a small control FSM sit between the two.

---
 rtl/ddr_activation_reader_if.sv | 29 ++
 rtl/ddr_activation_reader.sv | 135 +++++++++++++
 tb/tb_ddr_activation_reader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_activation_reader_if.sv
// Stream bundle for the activation reader: DDR beat input and unpacked element output.
interface ddr_activation_reader_if #(
  parameter int DDR_W = 216,
  parameter int ROW_W = 10,
  parameter int COL_W = 11,
  parameter int CH_W  = 8
);
  logic             ddr_valid;
  logic             ddr_ready;
  logic [DDR_W-1:0] ddr_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic [CH_W-1:0]  out_ch;
  logic             out_last;

  // master is the reader; slave is the DDR source / downstream consumer side.
  modport master (
    input  ddr_valid, ddr_data, out_ready,
    output ddr_ready, out_valid, out_data, out_row, out_col, out_ch, out_last
  );

  modport slave (
    output ddr_valid, ddr_data, out_ready,
    input  ddr_ready, out_valid, out_data, out_row, out_col, out_ch, out_last
  );
endinterface

// File: rtl/ddr_activation_reader.sv
// Unpacks 27-byte DDR beats into a one-byte-per-cycle activation stream
// tagged with row/col/channel addresses (channel fastest).
module ddr_activation_reader #(
  parameter int DDR_W          = 216,
  parameter int BYTES_PER_BEAT = 27,
  parameter int ROW_W          = 10,
  parameter int COL_W          = 11,
  parameter int CH_W           = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [ROW_W-1:0] cfg_rows,
  input  logic [COL_W-1:0] cfg_cols,
  input  logic [CH_W-1:0]  cfg_chs,
  ddr_activation_reader_if.master bus,
  output logic             busy,
  output logic             done
);
  localparam int N_W   = ROW_W + COL_W + CH_W;
  localparam int IDX_W = $clog2(BYTES_PER_BEAT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] cols_q, col_q;
  logic [CH_W-1:0]  chs_q, ch_q;
  logic [ROW_W-1:0] row_q;
  logic [N_W-1:0]   n_q, elem_q, n_calc;
  logic [N_W:0]     loaded_q;
  logic [DDR_W-1:0] beat_p0;
  logic             vld_p0;
  logic [IDX_W-1:0] idx_p0;
  logic             start_ok, zero_dim, out_fire, last_byte, last_elem, ddr_fire;

  assign n_calc   = N_W'(cfg_rows) * N_W'(cfg_cols) * N_W'(cfg_chs);
  assign zero_dim = (cfg_rows == '0) || (cfg_cols == '0) || (cfg_chs == '0);
  assign start_ok = (state_q == IDLE) && start;

  assign bus.out_valid = vld_p0 && (state_q == RUN);
  assign out_fire      = bus.out_valid && bus.out_ready;
  assign last_byte     = (idx_p0 == IDX_W'(BYTES_PER_BEAT - 1));
  assign bus.out_last  = bus.out_valid && (elem_q == n_q - N_W'(1));
  assign last_elem     = out_fire && bus.out_last;

  // loaded_q counts elements brought in so far; comparing it to N is the
  // same as comparing beats received against ceil(N/27) without a divider.
  assign bus.ddr_ready = (state_q == RUN) && (loaded_q < {1'b0, n_q}) &&
                         (!vld_p0 || (out_fire && last_byte));
  assign ddr_fire      = bus.ddr_valid && bus.ddr_ready;

  assign bus.out_data = bus.out_valid ? beat_p0[7:0] : 8'd0;
  assign bus.out_row  = row_q;
  assign bus.out_col  = col_q;
  assign bus.out_ch   = ch_q;
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = zero_dim ? DONE : RUN;
      RUN:     if (last_elem) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p0   <= 1'b0;
      idx_p0   <= '0;
      cols_q   <= '0;
      chs_q    <= '0;
      n_q      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      ch_q     <= '0;
      elem_q   <= '0;
      loaded_q <= '0;
    end else if (start_ok) begin
      vld_p0   <= 1'b0;
      idx_p0   <= '0;
      cols_q   <= cfg_cols;
      chs_q    <= cfg_chs;
      n_q      <= n_calc;
      row_q    <= '0;
      col_q    <= '0;
      ch_q     <= '0;
      elem_q   <= '0;
      loaded_q <= '0;
    end else begin
      if (out_fire) begin
        idx_p0 <= idx_p0 + IDX_W'(1);
        elem_q <= elem_q + N_W'(1);
        if (ch_q == chs_q - CH_W'(1)) begin
          ch_q <= '0;
          if (col_q == cols_q - COL_W'(1)) begin
            col_q <= '0;
            row_q <= row_q + ROW_W'(1);
          end else begin
            col_q <= col_q + COL_W'(1);
          end
        end else begin
          ch_q <= ch_q + CH_W'(1);
        end
        // The tail of a partial final beat is dropped with the last element.
        if (last_byte || bus.out_last) vld_p0 <= 1'b0;
      end
      if (ddr_fire) begin
        vld_p0   <= 1'b1;
        idx_p0   <= '0;
        loaded_q <= loaded_q + (N_W + 1)'(BYTES_PER_BEAT);
      end
    end
  end

  // Beat buffer stage: byte 0 sits at the bottom and shifts out one per fire.
  always_ff @(posedge clock) begin
    if (ddr_fire) begin
      beat_p0 <= bus.ddr_data;
    end else if (out_fire) begin
      beat_p0 <= beat_p0 >> 8;
    end
  end

endmodule

// File: tb/tb_ddr_activation_reader.sv
// Randomized self-checking bench for ddr_activation_reader against an
// index-arithmetic model of the unpacked stream.
module tb_ddr_activation_reader;
  localparam int DDR_W = 216, BPB = 27, ROW_W = 10, COL_W = 11, CH_W = 8;

  logic             clock = 1'b0;
  logic             reset, start;
  logic [ROW_W-1:0] cfg_rows;
  logic [COL_W-1:0] cfg_cols;
  logic [CH_W-1:0]  cfg_chs;
  logic             busy, done;
  int               total = 0, bad = 0;

  ddr_activation_reader_if #(.DDR_W(DDR_W), .ROW_W(ROW_W), .COL_W(COL_W), .CH_W(CH_W)) bus ();

  ddr_activation_reader #(
    .DDR_W(DDR_W), .BYTES_PER_BEAT(BPB), .ROW_W(ROW_W), .COL_W(COL_W), .CH_W(CH_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_chs(cfg_chs),
    .bus(bus), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Streams one map. rmode: 0 = ready held high, 1 = toggling, 2 = random.
  task automatic run_map(input int r, input int c, input int h, input int vpct,
                         input int rmode, input bit seq, input bit inj, input int stop_after,
                         output int sent, output int acc, output int first_fire,
                         output int last_fire, output int gap_bad);
    int n, nb, cyc, avail, last_beat_cyc, er, ec, eh;
    bit exp_valid, exp_ready, exp_last, stall, finished;
    logic [36:0] held;
    logic [7:0] eb;
    logic [DDR_W-1:0] bq[$];
    logic [DDR_W-1:0] tmp;
    n  = r * c * h;
    nb = (n + BPB - 1) / BPB;
    for (int b = 0; b <= nb; b++) begin
      for (int k = 0; k < BPB; k++)
        tmp[k*8 +: 8] = seq ? 8'((b * BPB + k) & 255) : 8'($urandom_range(0, 255));
      bq.push_back(tmp);
    end
    sent = 0; acc = 0; first_fire = -1; last_fire = -1; gap_bad = 0;
    stall = 0; finished = 0; last_beat_cyc = -1; held = '0;
    @(negedge clock);
    cfg_rows = ROW_W'(r); cfg_cols = COL_W'(c); cfg_chs = CH_W'(h); start = 1'b1;
    @(negedge clock);
    for (cyc = 0; cyc < 4000; cyc++) begin
      if (inj && cyc == 5) begin
        start = 1'b1; cfg_rows = 3; cfg_cols = 3; cfg_chs = 3;
      end else begin
        start = 1'b0;
      end
      bus.ddr_valid = ($urandom_range(0, 99) < vpct);
      bus.ddr_data  = bq[acc];
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 2 == 0);
        default: bus.out_ready = ($urandom_range(0, 1) == 1);
      endcase
      #1;
      avail = acc * BPB - sent;
      if (sent == n) begin
        total++;
        if ({done, busy, bus.ddr_ready, bus.out_valid} !== 4'b1000) begin
          bad++;
          $display("FAIL done_cycle: got done/busy/rdy/vld=%b want 1000", {done, busy, bus.ddr_ready, bus.out_valid});
        end
        finished = 1;
        break;
      end
      exp_valid = (avail > 0);
      exp_ready = (acc < nb) && ((avail == 0) || (avail == 1 && bus.out_ready));
      exp_last  = exp_valid && (sent == n - 1);
      total++;
      if ({busy, done, bus.out_valid, bus.ddr_ready, bus.out_last} !== {2'b10, exp_valid, exp_ready, exp_last}) begin
        bad++;
        $display("FAIL ctl cyc=%0d: got busy/done/vld/rdy/last=%b want %b", cyc,
                 {busy, done, bus.out_valid, bus.ddr_ready, bus.out_last}, {2'b10, exp_valid, exp_ready, exp_last});
      end
      if (stall) begin
        total++;
        if ({bus.out_data, bus.out_row, bus.out_col, bus.out_ch} !== held) begin
          bad++;
          $display("FAIL hold cyc=%0d: got %h want %h", cyc, {bus.out_data, bus.out_row, bus.out_col, bus.out_ch}, held);
        end
      end
      if (bus.out_valid && exp_valid) begin
        eh  = sent % h;
        ec  = (sent / h) % c;
        er  = sent / (h * c);
        tmp = bq[sent / BPB];
        eb  = tmp[(sent % BPB) * 8 +: 8];
        total++;
        if ({bus.out_data, bus.out_row, bus.out_col, bus.out_ch} !== {eb, ROW_W'(er), COL_W'(ec), CH_W'(eh)}) begin
          bad++;
          $display("FAIL elem %0d: got data/row/col/ch=%h/%0d/%0d/%0d want %h/%0d/%0d/%0d", sent,
                   bus.out_data, bus.out_row, bus.out_col, bus.out_ch, eb, er, ec, eh);
        end
        if (bus.out_ready) begin
          sent++;
          if (first_fire < 0) first_fire = cyc;
          last_fire = cyc;
        end
      end
      stall = bus.out_valid && !bus.out_ready;
      held  = {bus.out_data, bus.out_row, bus.out_col, bus.out_ch};
      if (bus.ddr_valid && bus.ddr_ready) begin
        if (last_beat_cyc >= 0 && cyc - last_beat_cyc != BPB) gap_bad++;
        last_beat_cyc = cyc;
        acc++;
      end
      if (stop_after > 0 && sent == stop_after) break;
      @(negedge clock);
    end
    start = 1'b0;
    if (finished) begin
      @(negedge clock);
      #1;
      total++;
      if ({done, busy} !== 2'b00) begin
        bad++;
        $display("FAIL done_pulse: got done/busy=%b want 00", {done, busy});
      end
    end else if (!(stop_after > 0 && sent == stop_after)) begin
      total++; bad++;
      $display("FAIL timeout: got %0d elements want %0d", sent, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; cfg_rows = '0; cfg_cols = '0; cfg_chs = '0;
    bus.ddr_valid = 1'b0; bus.ddr_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    total++;
    if ({bus.ddr_ready, bus.out_valid, bus.out_last, busy, done, bus.out_data,
         bus.out_row, bus.out_col, bus.out_ch} !== 42'd0) begin
      bad++;
      $display("FAIL reset_state: got %h want 0", {bus.ddr_ready, bus.out_valid, bus.out_last, busy, done,
               bus.out_data, bus.out_row, bus.out_col, bus.out_ch});
    end
    reset = 1'b0;
  endtask

  task automatic test_single_beat();
    int s, a, f, l, g;
    run_map(1, 3, 9, 100, 0, 1'b1, 1'b0, 0, s, a, f, l, g);
    total++;
    if ({s, a, l - f} !== {32'd27, 32'd1, 32'd26}) begin
      bad++;
      $display("FAIL single_beat: got sent=%0d beats=%0d span=%0d want 27 1 26", s, a, l - f);
    end
  endtask

  task automatic test_partial();
    int s, a, f, l, g;
    run_map(2, 2, 10, 100, 0, 1'b0, 1'b0, 0, s, a, f, l, g);
    total++;
    if ({s, a} !== {32'd40, 32'd2}) begin
      bad++;
      $display("FAIL partial: got sent=%0d beats=%0d want 40 2", s, a);
    end
  endtask

  task automatic test_back_to_back();
    int s, a, f, l, g;
    run_map(1, 1, 81, 100, 0, 1'b0, 1'b0, 0, s, a, f, l, g);
    total++;
    if ({s, a, l - f, g} !== {32'd81, 32'd3, 32'd80, 32'd0}) begin
      bad++;
      $display("FAIL back_to_back: got sent=%0d beats=%0d span=%0d gapbad=%0d want 81 3 80 0", s, a, l - f, g);
    end
  endtask

  task automatic test_backpressure();
    int s, a, f, l, g;
    run_map(1, 1, 27, 100, 1, 1'b0, 1'b1, 0, s, a, f, l, g);
    total++;
    if ({s, a} !== {32'd27, 32'd1}) begin
      bad++;
      $display("FAIL backpressure: got sent=%0d beats=%0d want 27 1", s, a);
    end
  endtask

  task automatic test_zero_start();
    @(negedge clock);
    cfg_rows = 2; cfg_cols = 2; cfg_chs = 0; start = 1'b1; bus.ddr_valid = 1'b1;
    @(negedge clock);
    start = 1'b0;
    #1;
    total++;
    if ({done, busy, bus.ddr_ready} !== 3'b100) begin
      bad++;
      $display("FAIL zero_start: got done/busy/rdy=%b want 100", {done, busy, bus.ddr_ready});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      total++;
      if ({done, busy, bus.ddr_ready} !== 3'b000) begin
        bad++;
        $display("FAIL zero_after: got done/busy/rdy=%b want 000", {done, busy, bus.ddr_ready});
      end
    end
  endtask

  task automatic test_reset_mid();
    int s, a, f, l, g;
    run_map(1, 1, 27, 100, 0, 1'b0, 1'b0, 10, s, a, f, l, g);
    reset = 1'b1;
    @(negedge clock);
    #1;
    total++;
    if ({bus.ddr_ready, bus.out_valid, bus.out_last, busy, done, bus.out_data,
         bus.out_row, bus.out_col, bus.out_ch} !== 42'd0) begin
      bad++;
      $display("FAIL reset_mid: got %h want 0", {bus.ddr_ready, bus.out_valid, bus.out_last, busy, done,
               bus.out_data, bus.out_row, bus.out_col, bus.out_ch});
    end
    reset = 1'b0;
    run_map(1, 1, 27, 80, 2, 1'b0, 1'b0, 0, s, a, f, l, g);
    total++;
    if (s !== 27) begin
      bad++;
      $display("FAIL reset_restart: got sent=%0d want 27", s);
    end
  endtask

  task automatic test_random();
    int s, a, f, l, g, r, c, h;
    for (int i = 0; i < 5; i++) begin
      r = $urandom_range(1, 3); c = $urandom_range(1, 4); h = $urandom_range(1, 12);
      run_map(r, c, h, $urandom_range(30, 100), 2, 1'b0, 1'b0, 0, s, a, f, l, g);
      total++;
      if ({s, a} !== {r * c * h, (r * c * h + BPB - 1) / BPB}) begin
        bad++;
        $display("FAIL random_map %0dx%0dx%0d: got sent=%0d beats=%0d", r, c, h, s, a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_partial();
    test_back_to_back();
    test_backpressure();
    test_zero_start();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
